// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point radix-2 SDF FFT pipeline: sizes, the
// complex sample type, the Q1.14 twiddle table and a DW saturation helper.
package fft_pkg;

    localparam int N    = 32;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int LOGN = $clog2(N);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } tw_t;

    // W^m = cos(2*pi*m/32) - j*sin(2*pi*m/32) in Q1.14; im already carries the minus sign.
    function automatic tw_t tw(input logic [LOGN-2:0] m);
        tw_t w;
        case (m)
            4'd0:    w = '{re:  16'sd16384, im:   16'sd0};
            4'd1:    w = '{re:  16'sd16069, im:  -16'sd3196};
            4'd2:    w = '{re:  16'sd15137, im:  -16'sd6270};
            4'd3:    w = '{re:  16'sd13623, im:  -16'sd9102};
            4'd4:    w = '{re:  16'sd11585, im: -16'sd11585};
            4'd5:    w = '{re:   16'sd9102, im: -16'sd13623};
            4'd6:    w = '{re:   16'sd6270, im: -16'sd15137};
            4'd7:    w = '{re:   16'sd3196, im: -16'sd16069};
            4'd8:    w = '{re:      16'sd0, im: -16'sd16384};
            4'd9:    w = '{re:  -16'sd3196, im: -16'sd16069};
            4'd10:   w = '{re:  -16'sd6270, im: -16'sd15137};
            4'd11:   w = '{re:  -16'sd9102, im: -16'sd13623};
            4'd12:   w = '{re: -16'sd11585, im: -16'sd11585};
            4'd13:   w = '{re: -16'sd13623, im:  -16'sd9102};
            4'd14:   w = '{re: -16'sd15137, im:  -16'sd6270};
            default: w = '{re: -16'sd16069, im:  -16'sd3196};
        endcase
        return w;
    endfunction

    // Clamp a wide signed value to the DW range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+TW:0] v);
        if (&v[DW+TW:DW-1] || ~|v[DW+TW:DW-1])
            return v[DW-1:0];
        return v[DW+TW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fft_sdf_stage_if.sv
// Sample stream into and out of one SDF stage. The upstream side (master)
// drives in_*, the stage (slave) drives out_*.
interface fft_sdf_stage_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic                 out_valid;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;

    modport master (
        output in_valid, in_r, in_i,
        input  out_valid, out_r, out_i
    );

    modport slave (
        input  in_valid, in_r, in_i,
        output out_valid, out_r, out_i
    );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup. The stored table is the 32-point one; shorter
// transforms step through it with a stride of 32/N.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N  = fft_pkg::N,
    parameter int TW = fft_pkg::TW
) (
    input  logic [$clog2(N)-2:0] m,
    output logic signed [TW-1:0] w_r,
    output logic signed [TW-1:0] w_i
);
    localparam int STEP = 32 / N;

    tw_t w;

    // Table lookup, index scaled onto the 32-point table.
    always_comb begin
        w   = tw((LOGN-1)'(int'(m) * STEP));
        w_r = TW'(w.re);
        w_i = TW'(w.im);
    end

endmodule

// File: rtl/fft_sdf_stage.sv
// One radix-2 DIF single-path-delay-feedback stage. The first D samples of
// each 2D block are parked in the delay line while the previous block's
// differences are rotated by the twiddle and sent out; the second D samples
// meet their partners at the head of the line, the half-sum goes out and the
// half-difference is parked for the next block.
module fft_sdf_stage #(
    parameter int N     = fft_pkg::N,
    parameter int STAGE = 0,
    parameter int DW    = fft_pkg::DW,
    parameter int TW    = fft_pkg::TW
) (
    input logic             clk,
    input logic             rst,
    fft_sdf_stage_if.slave  bus
);
    localparam int D    = N >> (STAGE + 1);
    localparam int CW   = $clog2(2 * D);
    localparam int MW   = $clog2(N) - 1;
    localparam int PRW  = DW + TW;
    localparam int PW   = PRW + 1;
    localparam int FRAC = TW - 2;
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } samp_t;

    // (a+b)>>>1 at DW+1 bits; the halving keeps the result inside DW.
    function automatic logic signed [DW-1:0] half_add(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        return s[DW:1];
    endfunction

    // (a-b)>>>1 at DW+1 bits.
    function automatic logic signed [DW-1:0] half_sub(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} - {b[DW-1], b};
        return s[DW:1];
    endfunction

    // Round half-up at the Q1.14 point, then clamp to DW.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        r = (v + RND) >>> FRAC;
        if (&r[PW-1:DW-1] || ~|r[PW-1:DW-1])
            return r[DW-1:0];
        return r[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

    logic [CW-1:0]         cnt;
    logic                  primed;
    logic                  bfly_ph;
    samp_t                 fifo [D];
    samp_t                 head;
    samp_t                 x;
    samp_t                 sum;
    samp_t                 diff;
    samp_t                 prod;
    samp_t                 push;
    samp_t                 res;
    logic [MW-1:0]         m;
    logic signed [TW-1:0]  w_r;
    logic signed [TW-1:0]  w_i;
    logic signed [PRW-1:0] p_rr;
    logic signed [PRW-1:0] p_ii;
    logic signed [PRW-1:0] p_ri;
    logic signed [PRW-1:0] p_ir;

    // The upper half of the count window is the butterfly phase.
    assign bfly_ph = cnt[CW-1];

    // Twiddle exponent is j<<STAGE with j the position inside the half block.
    if (D == 1) begin : g_m_zero
        assign m = '0;
    end else begin : g_m_pos
        assign m = MW'(cnt[CW-2:0]) << STAGE;
    end

    fft_twiddle_rom #(
        .N  (N),
        .TW (TW)
    ) u_rom (
        .m   (m),
        .w_r (w_r),
        .w_i (w_i)
    );

    // Butterfly, twiddle rotation and the phase-dependent output/push selection.
    always_comb begin
        x.re    = bus.in_r;
        x.im    = bus.in_i;
        head    = fifo[D-1];
        sum.re  = half_add(head.re, x.re);
        sum.im  = half_add(head.im, x.im);
        diff.re = half_sub(head.re, x.re);
        diff.im = half_sub(head.im, x.im);
        p_rr    = PRW'(head.re) * PRW'(w_r);
        p_ii    = PRW'(head.im) * PRW'(w_i);
        p_ri    = PRW'(head.re) * PRW'(w_i);
        p_ir    = PRW'(head.im) * PRW'(w_r);
        prod.re = round_sat({p_rr[PRW-1], p_rr} - {p_ii[PRW-1], p_ii});
        prod.im = round_sat({p_ri[PRW-1], p_ri} + {p_ir[PRW-1], p_ir});
        res     = bfly_ph ? sum  : prod;
        push    = bfly_ph ? diff : x;
    end

    // Sample counter and priming flag; both move only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(D - 1))
                primed <= 1'b1;
        end
    end

    // D-deep delay line: new entry at index 0, oldest at D-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++)
                fifo[i] <= '0;
        end else if (bus.in_valid) begin
            fifo[0] <= push;
            for (int i = 1; i < D; i++)
                fifo[i] <= fifo[i-1];
        end
    end

    // ---- output register stage ----
    // Registered result; data holds across idle cycles, valid does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
        end else begin
            bus.out_valid <= bus.in_valid & primed;
            if (bus.in_valid) begin
                bus.out_r <= res.re;
                bus.out_i <= res.im;
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Scoreboard bench for fft_sdf_stage: a D=16 instance (STAGE=0) and a D=1
// instance (STAGE=4) driven with directed vectors whose outputs are written
// out by hand.
module tb_fft_sdf_stage;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic end_req;

    always #5 clk = ~clk;

    fft_sdf_stage_if #(.DW(DW)) bus0 ();
    fft_sdf_stage_if #(.DW(DW)) bus4 ();

    fft_sdf_stage #(.N(N), .STAGE(0), .DW(DW), .TW(TW)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    fft_sdf_stage #(.N(N), .STAGE(4), .DW(DW), .TW(TW)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int    checks = 0;
    int    errors = 0;
    cplx_t exp_q [2][$];
    logic  last_iv [2] = '{1'b0, 1'b0};
    logic  last_rst = 1'b0;

    // What the DUTs sampled on the last rising edge.
    always @(posedge clk) begin
        last_iv[0] <= bus0.in_valid;
        last_iv[1] <= bus4.in_valid;
        last_rst   <= rst;
    end

    function automatic void chk(input int k, input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL stage%0d_%s actual=%0d required=%0d t=%0t", k * 4, name, act, req, $time);
        end
    endfunction

    function automatic void mon_one(input int k, input logic v, input int r, input int i);
        cplx_t e;
        if (!last_iv[k])
            chk(k, "gap_valid", int'(v), 0);
        if (v) begin
            if (exp_q[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stage%0d_extra_out actual=%0d,%0d required=none t=%0t", k * 4, r, i, $time);
            end else begin
                e = exp_q[k].pop_front();
                chk(k, "out_r", r, int'(e.re));
                chk(k, "out_i", i, int'(e.im));
            end
        end
    endfunction

    // Monitor: reset state, gap alignment and in-order scoreboard compare.
    always @(negedge clk) begin
        if (last_rst) begin
            chk(0, "rst_valid", int'(bus0.out_valid), 0);
            chk(0, "rst_r", int'(bus0.out_r), 0);
            chk(0, "rst_i", int'(bus0.out_i), 0);
            chk(1, "rst_valid", int'(bus4.out_valid), 0);
            chk(1, "rst_r", int'(bus4.out_r), 0);
            chk(1, "rst_i", int'(bus4.out_i), 0);
        end else begin
            mon_one(0, bus0.out_valid, int'(bus0.out_r), int'(bus0.out_i));
            mon_one(1, bus4.out_valid, int'(bus4.out_r), int'(bus4.out_i));
        end
        if (end_req) begin
            chk(0, "pending", exp_q[0].size(), 0);
            chk(1, "pending", exp_q[1].size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic put(input int k, input logic v, input int r, input int i);
        if (k == 0) begin
            bus0.in_valid = v;
            bus0.in_r     = DW'(r);
            bus0.in_i     = DW'(i);
        end else begin
            bus4.in_valid = v;
            bus4.in_r     = DW'(r);
            bus4.in_i     = DW'(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int k, input int r, input int i);
        cplx_t e;
        e.re = DW'(r);
        e.im = DW'(i);
        exp_q[k].push_back(e);
    endtask

    // One reset cycle with live, valid-looking junk on both inputs.
    task automatic pulse_rst();
        rst = 1'b1;
        put(0, 1'b1, 777, -777);
        rst = 1'b0;
        bus0.in_valid = 1'b0;
    endtask

    // Impulse frame x[0]=1000 plus 16 flush zeros; idx counts accepted samples.
    task automatic impulse_expect(input int idx);
        if (idx == 16 || idx == 32)
            expect_out(0, 500, 0);
        else if (idx > 16)
            expect_out(0, 0, 0);
    endtask

    logic [4:0] pat = 5'b01101;

    initial begin
        end_req = 1'b0;
        rst     = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_r = '0; bus0.in_i = '0;
        bus4.in_valid = 1'b0; bus4.in_r = '0; bus4.in_i = '0;

        // Reset held for two edges with random traffic on both inputs.
        for (int c = 0; c < 2; c++) begin
            bus0.in_valid = 1'($urandom);
            bus0.in_r     = DW'($urandom);
            bus0.in_i     = DW'($urandom);
            bus4.in_valid = 1'($urandom);
            bus4.in_r     = DW'($urandom);
            bus4.in_i     = DW'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus0.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        put(1, 1'b0, 0, 0);

        // D=1: 100, 40, 0, 0 -> 70, 30, 0 after an unprimed first sample.
        put(1, 1'b1, 100, 0);
        expect_out(1, 70, 0);  put(1, 1'b1, 40, 0);
        expect_out(1, 30, 0);  put(1, 1'b1, 0, 0);
        expect_out(1, 0, 0);   put(1, 1'b1, 0, 0);
        put(1, 1'b0, 0, 0);

        // D=1 extremes: half-sum/half-diff at the edges of the DW range.
        pulse_rst();
        put(1, 1'b1, -32768, 32767);
        expect_out(1, -1, -1);         put(1, 1'b1, 32767, -32768);
        expect_out(1, -32768, 32767);  put(1, 1'b1, 32767, -32768);
        expect_out(1, 32767, -32768);  put(1, 1'b1, 32767, -32768);
        expect_out(1, 0, 0);           put(1, 1'b1, 0, 0);
        expect_out(1, 0, 0);           put(1, 1'b1, 0, 0);
        put(1, 1'b0, 0, 0);

        // D=16: impulse frame, then x[1]=x[4]=x[8]=1000 frame back-to-back, then flush.
        pulse_rst();
        for (int idx = 0; idx < 32; idx++) begin
            impulse_expect(idx);
            put(0, 1'b1, (idx == 0) ? 1000 : 0, 0);
        end
        for (int idx = 0; idx < 32; idx++) begin
            if (idx < 16)
                expect_out(0, (idx == 0) ? 500 : 0, 0);
            else if (idx == 17 || idx == 20 || idx == 24)
                expect_out(0, 500, 0);
            else
                expect_out(0, 0, 0);
            put(0, 1'b1, (idx == 1 || idx == 4 || idx == 8) ? 1000 : 0, 0);
        end
        for (int j = 0; j < 16; j++) begin
            case (j)
                1:       expect_out(0, 490, -98);
                4:       expect_out(0, 354, -354);
                8:       expect_out(0, 0, -500);
                default: expect_out(0, 0, 0);
            endcase
            put(0, 1'b1, 0, 0);
        end
        put(0, 1'b0, 0, 0);

        // Mid-frame reset after 10 samples, then the impulse frame with gaps.
        pulse_rst();
        for (int c = 0; c < 10; c++)
            put(0, 1'b1, 300 + 7 * c, -50 * c);
        pulse_rst();
        begin
            int idx = 0;
            int c   = 0;
            while (idx < 48) begin
                if (pat[c % 5]) begin
                    impulse_expect(idx);
                    put(0, 1'b1, (idx == 0) ? 1000 : 0, 0);
                    idx++;
                end else begin
                    put(0, 1'b0, 12345, -12345);
                end
                c++;
            end
        end
        put(0, 1'b0, 0, 0);
        put(0, 1'b0, 0, 0);

        end_req = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_end actual=running required=finished");
        $fatal(1, "monitor did not finish");
    end

endmodule
